gat_host_load_ctrl: RTL and testbench

// - Multi-channel host-to-core load/run controller; sits between the PS register bank / AXI-BRAM ports and gat_top.
// - Converts 32-bit byte-addressed host writes into word-addressed internal BRAM writes.
// - Counts words per channel and tracks per-channel load completion.
// - Sequences a layer run: start pulse, wait for core done, ready/status and cycle-count debug words.

---
 rtl/gat_pkg.sv | 28 ++
 rtl/gat_load_chan.sv | 121 ++++++++++++
 rtl/gat_host_load_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gat_host_load_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared definitions for the GAT host load/run controller.
//   - gat_state_e : run-sequencer state encoding (also reported in dbg_status[2:0])
//   - STAT_*      : bit positions of the fields packed into dbg_status
package gat_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } gat_state_e;

    // dbg_status = {zero pad, err_run[N], err_align[N], done[N], state[2:0]}
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE_LSB  = STATE_W;

    function automatic int stat_align_lsb(input int num_ch);
        return STAT_DONE_LSB + num_ch;
    endfunction

    function automatic int stat_run_lsb(input int num_ch);
        return STAT_DONE_LSB + 2 * num_ch;
    endfunction

endpackage

// File: rtl/gat_load_chan.sv
// One host load channel.
//   Checks word alignment of a host byte-addressed write, forwards accepted
//   writes to the internal BRAM port one cycle later (word address, narrowed
//   data), counts accepted words and keeps the sticky done / error flags.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ena, wea, addra     host port enable, write enable, byte address
//   din                 host write data, already narrowed to DATA_W
//   exp_cnt             expected word count (0 = rely on load_done_in only)
//   load_done_in        host load-complete strobe
//   clear               zero counter, flags and errors; drop any write
//   wr_allow            sequencer is in a state where BRAM may be written
//   run_block           sequencer is running; aligned writes are errors
//   restart             new load begins: counter and done flag restart at 0
//   accept              this cycle's write is accepted (combinational)
//   done, err_align, err_run   sticky status flags
//   bram_we, bram_addr, bram_din   registered internal BRAM write port
module gat_load_chan
    import gat_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 20,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W+1:0] addra,
    input  logic [DATA_W-1:0] din,
    input  logic [CNT_W-1:0]  exp_cnt,
    input  logic              load_done_in,
    input  logic              clear,
    input  logic              wr_allow,
    input  logic              run_block,
    input  logic              restart,
    output logic              accept,
    output logic              done,
    output logic              err_align,
    output logic              err_run,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din
);

    logic              req;
    logic              misaligned;
    logic [CNT_W-1:0]  cnt_base;
    logic              done_base;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_align_q, err_align_d;
    logic              err_run_q, err_run_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    always_comb begin
        // NOTE: every signal written here is given a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        req        = ena & wea & ~clear;
        misaligned = (addra[1:0] != 2'b00);
        accept     = req & ~misaligned & wr_allow;

        // A restarting load forgets the previous run's count before this
        // cycle's write is added.
        cnt_base  = restart ? '0 : cnt_q;
        done_base = restart ? 1'b0 : done_q;

        cnt_d = cnt_base;
        if (accept && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end

        done_d      = done_base | load_done_in | ((exp_cnt != '0) && (cnt_d == exp_cnt));
        err_align_d = err_align_q | (req & misaligned);
        err_run_d   = err_run_q | (req & ~misaligned & run_block);

        we_d   = accept;
        addr_d = accept ? addra[ADDR_W+1:2] : addr_q;
        din_d  = accept ? din : din_q;

        if (clear) begin
            cnt_d       = '0;
            done_d      = 1'b0;
            err_align_d = 1'b0;
            err_run_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_align_q <= 1'b0;
            err_run_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_align_q <= err_align_d;
            err_run_q   <= err_run_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign done      = done_q;
    assign err_align = err_align_q;
    assign err_run   = err_run_q;
    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;

endmodule

// File: rtl/gat_host_load_ctrl.sv
// Multi-channel host-to-core load/run controller between the PS register
// bank / AXI-BRAM ports and gat_top.
//   Host writes (byte addressed, 32-bit) become word-addressed internal BRAM
//   writes per channel; once every channel reports done the sequencer pulses
//   core_start, counts cycles until core_done and reports status.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   host_ena/wea    per-channel port enable / write enable
//   host_addra      per-channel byte address, packed, ch0 in LSBs
//   host_din        per-channel write data, packed
//   exp_cnt         per-channel expected word count (0 = strobe only)
//   load_done_in    per-channel host load-done strobe
//   gat_layer       layer select, latched when a run starts
//   clear           return to IDLE, zero counters/flags/errors
//   core_done       core finished the layer (pulse)
//   bram_we/addr/din  internal BRAM write ports, packed
//   core_start      one-cycle run pulse, core_layer latched layer select
//   gat_ready       host may load/read (IDLE or DONE)
//   dbg_cycles      cycles spent in RUN for the last run (saturating)
//   dbg_status      {pad, err_run, err_align, done, state}
module gat_host_load_ctrl
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 20,
    parameter int CNT_W     = ADDR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            host_ena,
    input  logic [NUM_CH-1:0]            host_wea,
    input  logic [NUM_CH*(ADDR_W+2)-1:0] host_addra,
    input  logic [NUM_CH*TOP_WIDTH-1:0]  host_din,
    input  logic [NUM_CH*CNT_W-1:0]      exp_cnt,
    input  logic [NUM_CH-1:0]            load_done_in,
    input  logic                         gat_layer,
    input  logic                         clear,
    input  logic                         core_done,
    output logic [NUM_CH-1:0]            bram_we,
    output logic [NUM_CH*ADDR_W-1:0]     bram_addr,
    output logic [NUM_CH*DATA_W-1:0]     bram_din,
    output logic                         core_start,
    output logic                         core_layer,
    output logic                         gat_ready,
    output logic [TOP_WIDTH-1:0]         dbg_cycles,
    output logic [TOP_WIDTH-1:0]         dbg_status
);

    localparam int HOST_AW   = ADDR_W + 2;
    localparam int ALIGN_LSB = stat_align_lsb(NUM_CH);
    localparam int RUN_LSB   = stat_run_lsb(NUM_CH);

    gat_state_e          state_q, state_d;
    logic [TOP_WIDTH-1:0] cycles_q, cycles_d;
    logic                 layer_q, layer_d;

    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] err_align;
    logic [NUM_CH-1:0] err_run;
    logic              wr_allow;
    logic              run_block;
    logic              restart;

    // START counts as part of the run: the core has been told to go, so the
    // BRAM must not change underneath it.
    assign wr_allow  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign run_block = (state_q == ST_START) || (state_q == ST_RUN);
    assign restart   = (state_q == ST_DONE) && (|accept);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        gat_load_chan #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .ena          (host_ena[c]),
            .wea          (host_wea[c]),
            .addra        (host_addra[c*HOST_AW +: HOST_AW]),
            .din          (host_din[c*TOP_WIDTH +: DATA_W]),
            .exp_cnt      (exp_cnt[c*CNT_W +: CNT_W]),
            .load_done_in (load_done_in[c]),
            .clear        (clear),
            .wr_allow     (wr_allow),
            .run_block    (run_block),
            .restart      (restart),
            .accept       (accept[c]),
            .done         (done[c]),
            .err_align    (err_align[c]),
            .err_run      (err_run[c]),
            .bram_we      (bram_we[c]),
            .bram_addr    (bram_addr[c*ADDR_W +: ADDR_W]),
            .bram_din     (bram_din[c*DATA_W +: DATA_W])
        );

        // Host data bits above the BRAM width are intentionally ignored.
        if (DATA_W < TOP_WIDTH) begin : g_pad
            logic unused_din_hi;
            assign unused_din_hi = ^host_din[c*TOP_WIDTH+DATA_W +: TOP_WIDTH-DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // Strobe-only loads can complete without any write.
                if (&done) begin
                    state_d = ST_START;
                end else if (|accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD:  if (&done) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (core_done) state_d = ST_DONE;
            ST_DONE:  if (|accept) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        cycles_d = cycles_q;
        layer_d  = layer_q;
        if ((state_q == ST_RUN) && (cycles_q != '1)) begin
            cycles_d = cycles_q + TOP_WIDTH'(1);
        end
        // Latch on entry so the layer is already valid during core_start.
        if ((state_d == ST_START) && (state_q != ST_START)) begin
            cycles_d = '0;
            layer_d  = gat_layer;
        end
        if (clear) begin
            cycles_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cycles_q <= '0;
            layer_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            layer_q  <= layer_d;
        end
    end

    always_comb begin
        dbg_status                                = '0;
        dbg_status[STAT_STATE_LSB +: STATE_W]     = state_q;
        dbg_status[STAT_DONE_LSB +: NUM_CH]       = done;
        dbg_status[ALIGN_LSB +: NUM_CH]           = err_align;
        dbg_status[RUN_LSB +: NUM_CH]             = err_run;
    end

    assign core_start = (state_q == ST_START);
    assign core_layer = layer_q;
    assign gat_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign dbg_cycles = cycles_q;

endmodule

// File: tb/tb_gat_host_load_ctrl.sv
module tb_gat_host_load_ctrl;

    localparam int TOP_WIDTH = 32;
    localparam int NUM_CH    = 3;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 20;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int AW        = ADDR_W + 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // Spec-level state numbers as reported in dbg_status[2:0].
    localparam int S_IDLE = 0, S_LOAD = 1, S_START = 2, S_RUN = 3, S_DONE = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_CH-1:0]           host_ena, host_wea, load_done_in;
    logic [NUM_CH*AW-1:0]        host_addra;
    logic [NUM_CH*TOP_WIDTH-1:0] host_din;
    logic [NUM_CH*CNT_W-1:0]     exp_cnt;
    logic                        gat_layer, clear, core_done;
    logic [NUM_CH-1:0]           bram_we;
    logic [NUM_CH*ADDR_W-1:0]    bram_addr;
    logic [NUM_CH*DATA_W-1:0]    bram_din;
    logic                        core_start, core_layer, gat_ready;
    logic [TOP_WIDTH-1:0]        dbg_cycles, dbg_status;

    gat_host_load_ctrl #(
        .TOP_WIDTH (TOP_WIDTH), .NUM_CH (NUM_CH), .ADDR_W (ADDR_W),
        .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst),
        .host_ena (host_ena), .host_wea (host_wea), .host_addra (host_addra),
        .host_din (host_din), .exp_cnt (exp_cnt), .load_done_in (load_done_in),
        .gat_layer (gat_layer), .clear (clear), .core_done (core_done),
        .bram_we (bram_we), .bram_addr (bram_addr), .bram_din (bram_din),
        .core_start (core_start), .core_layer (core_layer), .gat_ready (gat_ready),
        .dbg_cycles (dbg_cycles), .dbg_status (dbg_status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state;
    int          m_cnt  [NUM_CH];
    bit          m_done [NUM_CH];
    bit          m_ea   [NUM_CH];
    bit          m_er   [NUM_CH];
    bit          m_we   [NUM_CH];
    int          m_addr [NUM_CH];
    int          m_din  [NUM_CH];
    logic [31:0] m_cycles;
    bit          m_layer;

    task automatic model_reset();
        m_state  = S_IDLE;
        m_cycles = '0;
        m_layer  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_done[c] = 0; m_ea[c] = 0; m_er[c] = 0;
            m_we[c] = 0; m_addr[c] = 0; m_din[c] = 0;
        end
    endtask

    // Applies the spec rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        bit acc [NUM_CH];
        bit any_acc, all_done, req, mis, writable, running;
        int nxt, expc;
        if (clear) begin
            m_state  = S_IDLE;
            m_cycles = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0; m_done[c] = 0; m_ea[c] = 0; m_er[c] = 0; m_we[c] = 0;
            end
            return;
        end
        all_done = 1;
        for (int c = 0; c < NUM_CH; c++) all_done &= m_done[c];
        writable = (m_state == S_IDLE) || (m_state == S_LOAD) || (m_state == S_DONE);
        running  = (m_state == S_START) || (m_state == S_RUN);
        any_acc  = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            req    = host_ena[c] && host_wea[c];
            mis    = (host_addra[c*AW +: 2] != 2'b00);
            acc[c] = req && !mis && writable;
            if (req && mis) m_ea[c] = 1;
            if (req && !mis && running) m_er[c] = 1;
            any_acc |= acc[c];
        end
        nxt = m_state;
        case (m_state)
            S_IDLE:  if (all_done) nxt = S_START; else if (any_acc) nxt = S_LOAD;
            S_LOAD:  if (all_done) nxt = S_START;
            S_START: nxt = S_RUN;
            S_RUN:   if (core_done) nxt = S_DONE;
            S_DONE:  if (any_acc) nxt = S_LOAD;
            default: nxt = S_IDLE;
        endcase
        if (m_state == S_RUN && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (nxt == S_START && m_state != S_START) begin
            m_cycles = '0;
            m_layer  = gat_layer;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_state == S_DONE && any_acc) begin
                m_cnt[c]  = 0;
                m_done[c] = 0;
            end
            if (acc[c]) begin
                if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
                m_addr[c] = int'(host_addra[c*AW +: AW]) / 4;
                m_din[c]  = int'(host_din[c*TOP_WIDTH +: DATA_W]);
            end
            m_we[c] = acc[c];
            expc = int'(exp_cnt[c*CNT_W +: CNT_W]);
            if ((expc != 0 && m_cnt[c] == expc) || load_done_in[c]) m_done[c] = 1;
        end
        m_state = nxt;
    endtask

    task automatic check_outputs();
        logic [31:0] es;
        logic [NUM_CH-1:0] ewe;
        es = '0;
        es[2:0] = 3'(m_state);
        for (int c = 0; c < NUM_CH; c++) begin
            es[3 + c]            = m_done[c];
            es[3 + NUM_CH + c]   = m_ea[c];
            es[3 + 2*NUM_CH + c] = m_er[c];
            ewe[c]               = m_we[c];
        end
        check("dbg_status", dbg_status, es);
        check("bram_we", bram_we, ewe);
        check("core_start", core_start, (m_state == S_START));
        check("gat_ready", gat_ready, (m_state == S_IDLE || m_state == S_DONE));
        check("core_layer", core_layer, m_layer);
        check("dbg_cycles", dbg_cycles, m_cycles);
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_we[c]) begin
                check($sformatf("bram_addr%0d", c), bram_addr[c*ADDR_W +: ADDR_W], m_addr[c]);
                check($sformatf("bram_din%0d", c), bram_din[c*DATA_W +: DATA_W], m_din[c]);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        host_ena = '0; host_wea = '0; load_done_in = '0;
        clear = 1'b0; core_done = 1'b0;
    endtask

    task automatic set_wr(input int c, input int byte_addr, input logic [31:0] d);
        host_ena[c] = 1'b1;
        host_wea[c] = 1'b1;
        host_addra[c*AW +: AW] = AW'(byte_addr);
        host_din[c*TOP_WIDTH +: TOP_WIDTH] = d;
    endtask

    task automatic set_exp(input int e0, input int e1, input int e2);
        exp_cnt[0*CNT_W +: CNT_W] = CNT_W'(e0);
        exp_cnt[1*CNT_W +: CNT_W] = CNT_W'(e1);
        exp_cnt[2*CNT_W +: CNT_W] = CNT_W'(e2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r;
        rst = 1'b1;
        host_addra = '0; host_din = '0; exp_cnt = '0; gat_layer = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check("rst_ready", gat_ready, 1);
        check("rst_status", dbg_status, 0);
        check("rst_we", bram_we, 0);
        check("rst_start", core_start, 0);
        check("rst_cycles", dbg_cycles, 0);
        #10 rst = 1'b0;
        tick();

        // ---- aligned load: exp = ch0 3, ch1 2, ch2 4 ----
        set_exp(3, 2, 4);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            set_wr(0, i * 4, $urandom);
            tick();
            check("load_we0", bram_we[0], 1);
            check("load_addr0", bram_addr[ADDR_W-1:0], i);
        end
        check("load_done0", dbg_status[3], 1);
        check("load_state", dbg_status[2:0], S_LOAD);

        // ---- misaligned ch1 write ----
        idle_inputs();
        set_wr(1, 6, $urandom);
        tick();
        check("mis_we1", bram_we[1], 0);
        check("mis_err_align1", dbg_status[3 + NUM_CH + 1], 1);

        // ---- simultaneous ch1/ch2 writes ----
        idle_inputs(); set_wr(1, 'h10, $urandom); set_wr(2, 'h0, $urandom); tick();
        check("sim_we", bram_we, 3'b110);
        check("cnt1_unchanged", dbg_status[4], 0);
        idle_inputs(); set_wr(1, 'h14, $urandom); set_wr(2, 'h4, $urandom); tick();
        check("done1", dbg_status[4], 1);
        idle_inputs(); set_wr(2, 'h8, $urandom); tick();
        idle_inputs(); set_wr(2, 'hC, $urandom); tick();
        check("no_start_yet", core_start, 0);
        idle_inputs(); gat_layer = 1'b1; tick();
        check("start_pulse", core_start, 1);
        check("start_layer", core_layer, 1);
        gat_layer = 1'b0; tick();
        check("start_one_cycle", core_start, 0);

        // ---- RUN for 100 cycles, with a protected write ----
        for (int j = 0; j < 99; j++) begin
            idle_inputs();
            if (j == 40) set_wr(2, 'h40, $urandom);
            tick();
            if (j == 40) begin
                check("run_wr_dropped", bram_we[2], 0);
                check("run_err2", dbg_status[3 + 2*NUM_CH + 2], 1);
            end
        end
        idle_inputs(); core_done = 1'b1; set_wr(0, 'h30, $urandom); tick();
        check("run_cycles", dbg_cycles, 100);
        check("done_state", dbg_status[2:0], S_DONE);
        check("done_ready", gat_ready, 1);
        check("done_wr_dropped", bram_we[0], 0);
        check("done_err_run0", dbg_status[3 + 2*NUM_CH], 1);

        // ---- DONE -> LOAD restart ----
        idle_inputs(); set_wr(0, 'h20, $urandom); tick();
        check("restart_state", dbg_status[2:0], S_LOAD);
        check("restart_done_clr", dbg_status[5:3], 3'b000);
        check("restart_addr0", bram_addr[ADDR_W-1:0], 8);

        // ---- strobe path then clear in RUN ----
        idle_inputs(); clear = 1'b1; tick();
        check("clear_status", dbg_status, 0);
        set_exp(0, 0, 0);
        idle_inputs(); load_done_in = '1; tick();
        r = 1'($urandom);
        idle_inputs(); gat_layer = r; tick();
        check("strobe_start", core_start, 1);
        check("strobe_layer", core_layer, r);
        gat_layer = ~r;
        for (int j = 0; j < 4; j++) begin idle_inputs(); tick(); end
        idle_inputs(); clear = 1'b1; tick();
        check("clear_run_state", dbg_status[2:0], S_IDLE);
        check("clear_run_flags", dbg_status, 0);
        for (int j = 0; j < 3; j++) begin
            idle_inputs(); tick();
            check("clear_no_start", core_start, 0);
        end

        // ---- async reset mid-LOAD ----
        set_exp(3, 2, 4);
        idle_inputs(); set_wr(0, 'h4, $urandom); tick();
        check("pre_rst_we", bram_we[0], 1);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("async_we", bram_we, 0);
        check("async_status", dbg_status, 0);
        check("async_ready", gat_ready, 1);
        check("async_layer", core_layer, 0);
        model_reset();
        #2 rst = 1'b0;

        // ---- randomized phase ----
        for (int c = 0; c < NUM_CH; c++) exp_cnt[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
        for (int i = 0; i < 2000; i++) begin
            idle_inputs();
            gat_layer = 1'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                clear = 1'b1;
                for (int c = 0; c < NUM_CH; c++) exp_cnt[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_state != S_START && $urandom_range(0, 2) == 0) begin
                        int a;
                        a = $urandom_range(0, 63) * 4;
                        if (m_state != S_RUN && $urandom_range(0, 7) == 0) a += $urandom_range(1, 3);
                        set_wr(c, a, $urandom);
                        if ($urandom_range(0, 15) == 0) host_wea[c] = 1'b0;
                    end
                    if ($urandom_range(0, 19) == 0) load_done_in[c] = 1'b1;
                end
                if ((m_state == S_RUN && $urandom_range(0, 9) == 0) || $urandom_range(0, 39) == 0)
                    core_done = 1'b1;
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
